// File: rtl/sample_window_counter_if.sv
// Control/status bundle between the sample front end and the window counter.
// master drives the commands, slave (the counter) returns count and status.
`timescale 1ns/1ps
interface sample_window_counter_if #(
  parameter int CNT_BITS = 10
);
  logic                clear;
  logic                start;
  logic                cnt_up;
  logic                mode;
  logic                len_load;
  logic [CNT_BITS-1:0] len_in;
  logic [CNT_BITS-1:0] count;
  logic                window_done;
  logic                busy;
  logic                held;
  logic                overrun;

  modport master (
    output clear, start, cnt_up, mode, len_load, len_in,
    input  count, window_done, busy, held, overrun
  );

  modport slave (
    input  clear, start, cnt_up, mode, len_load, len_in,
    output count, window_done, busy, held, overrun
  );
endinterface

// File: rtl/sample_window_counter.sv
// Sample-window counter with programmable length, continuous or one-shot windows.
// Define SAMPLE_WINDOW_OVR_EN to build the sticky dropped-sample (overrun) detector.
`timescale 1ns/1ps
module sample_window_counter #(
  parameter int CNT_BITS    = 10,
  parameter int DEFAULT_LEN = 1000
) (
  input logic                     clk,
  input logic                     n_rst,
  sample_window_counter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [CNT_BITS-1:0] LP_DEFAULT_LEN = CNT_BITS'(DEFAULT_LEN);
  localparam logic [CNT_BITS-1:0] LP_ONE         = CNT_BITS'(1);

  state_t              r_state;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_BITS-1:0] r_win_len;
  logic                r_mode_q;
  logic                r_done;
  logic                r_busy;
  logic                r_held;
  logic                w_last;

  // win_len is never 0, so win_len-1 cannot underflow
  assign w_last = (r_count == (r_win_len - LP_ONE));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_win_len <= LP_DEFAULT_LEN;
      r_mode_q  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
        r_held  <= 1'b0;
      end else if (bus.start) begin
        // also restarts a running window; the coincident sample is dropped
        r_state  <= COUNT;
        r_count  <= '0;
        r_mode_q <= bus.mode;
        r_busy   <= 1'b1;
        r_held   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.len_load)
              r_win_len <= (bus.len_in == '0) ? LP_ONE : bus.len_in;
          end
          COUNT: begin
            if (bus.cnt_up) begin
              if (w_last) begin
                r_count <= '0;
                r_done  <= 1'b1;
                if (r_mode_q) begin
                  r_state <= HOLD;
                  r_busy  <= 1'b0;
                  r_held  <= 1'b1;
                end
              end else begin
                r_count <= r_count + LP_ONE;
              end
            end
          end
          HOLD: begin
            r_count <= '0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_held  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SAMPLE_WINDOW_OVR_EN
  logic r_overrun;

  // a sample arriving while not counting is lost; start/clear acknowledge it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_overrun <= 1'b0;
    else if (bus.clear || bus.start)
      r_overrun <= 1'b0;
    else if (bus.cnt_up && (r_state != COUNT))
      r_overrun <= 1'b1;
  end

  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.count       = r_count;
  assign bus.window_done = r_done;
  assign bus.busy        = r_busy;
  assign bus.held        = r_held;

endmodule

// File: tb/tb_sample_window_counter.sv
// Scenario bench for sample_window_counter: expected window_done pulses are
// queued by sample number and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_sample_window_counter;

  localparam int CNT_BITS = 10;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  int   tb_sample;
  int   exp_q[$];
  logic exp_ovr_en;

  sample_window_counter_if #(.CNT_BITS(CNT_BITS)) bus ();

  sample_window_counter #(
    .CNT_BITS    (CNT_BITS),
    .DEFAULT_LEN (1000)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // every window_done pulse must match the sample number queued for it
  always @(negedge clk) begin
    if (n_rst && bus.window_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: pulse after sample %0d, none expected", tb_sample);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (tb_sample !== e) begin
          errors++;
          $display("FAIL done_position: pulse after sample %0d, expected after sample %0d", tb_sample, e);
        end
      end
    end
  end

  task automatic clk_edge(input int sample_no);
    @(posedge clk);
    #1;
    tb_sample = sample_no;
  endtask

  task automatic drive_idle();
    bus.clear    = 1'b0;
    bus.start    = 1'b0;
    bus.cnt_up   = 1'b0;
    bus.mode     = 1'b0;
    bus.len_load = 1'b0;
    bus.len_in   = '0;
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_done: %0d pulses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    clk_edge(-1);
    bus.clear = 1'b0;
  endtask

  task automatic load_len(input int len);
    bus.len_load = 1'b1;
    bus.len_in   = CNT_BITS'(len);
    clk_edge(-1);
    bus.len_load = 1'b0;
  endtask

  task automatic do_start(input logic m);
    bus.start = 1'b1;
    bus.mode  = m;
    clk_edge(-1);
    bus.start = 1'b0;
    bus.mode  = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    if (bus.window_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.window_done); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", bus.held); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    n_rst = 1'b1;
    clk_edge(-1);
  endtask

  task automatic test_continuous();
    do_start(1'b0);
    checks += 2;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL cont_busy_start: got %b expected 1", bus.busy); end
    if (bus.count !== '0) begin errors++; $display("FAIL cont_count_start: got %0d expected 0", bus.count); end
    for (int i = 1; i <= 2000; i++) begin
      bus.cnt_up = 1'b1;
      if (i % 1000 == 0) exp_q.push_back(i);
      clk_edge(i);
      checks += 2;
      if (bus.count !== CNT_BITS'(i % 1000)) begin
        errors++; $display("FAIL cont_count: sample %0d got %0d expected %0d", i, bus.count, i % 1000);
      end
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL cont_busy: sample %0d got %b expected 1", i, bus.busy);
      end
    end
    bus.cnt_up = 1'b0;
    clk_edge(-1);
    checks++;
    if (bus.window_done !== 1'b0) begin errors++; $display("FAIL cont_pulse_width: got %b expected 0", bus.window_done); end
    check_queue_empty("cont");
    do_clear();
  endtask

  task automatic test_oneshot();
    load_len(5);
    do_start(1'b1);
    for (int i = 1; i <= 7; i++) begin
      bus.cnt_up = 1'b1;
      if (i == 5) exp_q.push_back(i);
      clk_edge(i);
      if (i == 5) begin
        checks += 3;
        if (bus.held !== 1'b1) begin errors++; $display("FAIL oneshot_held: got %b expected 1", bus.held); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy: got %b expected 0", bus.busy); end
        if (bus.count !== '0) begin errors++; $display("FAIL oneshot_count_done: got %0d expected 0", bus.count); end
      end
    end
    bus.cnt_up = 1'b0;
    clk_edge(-1);
    checks += 3;
    if (bus.count !== '0) begin errors++; $display("FAIL oneshot_count_hold: got %0d expected 0", bus.count); end
    if (bus.held !== 1'b1) begin errors++; $display("FAIL oneshot_held_after: got %b expected 1", bus.held); end
    if (bus.overrun !== exp_ovr_en) begin errors++; $display("FAIL oneshot_overrun: got %b expected %b", bus.overrun, exp_ovr_en); end
    check_queue_empty("oneshot");
    do_start(1'b0);
    checks += 3;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_restart_busy: got %b expected 1", bus.busy); end
    if (bus.held !== 1'b0) begin errors++; $display("FAIL hold_restart_held: got %b expected 0", bus.held); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL hold_restart_overrun: got %b expected 0", bus.overrun); end
    do_clear();
  endtask

  task automatic test_len_zero();
    load_len(0);
    do_start(1'b0);
    for (int i = 1; i <= 3; i++) begin
      bus.cnt_up = 1'b1;
      exp_q.push_back(i);
      clk_edge(i);
      checks++;
      if (bus.count !== '0) begin errors++; $display("FAIL len0_count: sample %0d got %0d expected 0", i, bus.count); end
    end
    bus.cnt_up = 1'b0;
    clk_edge(-1);
    check_queue_empty("len0");
    do_clear();
  endtask

  task automatic test_clear_mid();
    load_len(1000);
    do_start(1'b0);
    for (int i = 1; i <= 400; i++) begin
      bus.cnt_up = 1'b1;
      clk_edge(i);
    end
    bus.cnt_up = 1'b0;
    checks++;
    if (bus.count !== 10'd400) begin errors++; $display("FAIL clear_pre_count: got %0d expected 400", bus.count); end
    do_clear();
    checks += 3;
    if (bus.count !== '0) begin errors++; $display("FAIL clear_count: got %0d expected 0", bus.count); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b expected 0", bus.busy); end
    if (bus.window_done !== 1'b0) begin errors++; $display("FAIL clear_done: got %b expected 0", bus.window_done); end
    bus.start  = 1'b1;
    bus.cnt_up = 1'b1;
    clk_edge(-1);
    bus.start = 1'b0;
    checks += 2;
    if (bus.count !== '0) begin errors++; $display("FAIL start_cnt_same: got %0d expected 0", bus.count); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_cnt_busy: got %b expected 1", bus.busy); end
    clk_edge(1);
    bus.cnt_up = 1'b0;
    checks++;
    if (bus.count !== 10'd1) begin errors++; $display("FAIL start_cnt_next: got %0d expected 1", bus.count); end
    check_queue_empty("clear");
    do_clear();
  endtask

  task automatic test_len_load_in_count();
    do_start(1'b0);
    bus.len_load = 1'b1;
    bus.len_in   = 10'd3;
    clk_edge(-1);
    bus.len_load = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      bus.cnt_up = 1'b1;
      if (i == 1000) exp_q.push_back(i);
      clk_edge(i);
      if (i == 3 || i == 999) begin
        checks++;
        if (bus.count !== CNT_BITS'(i)) begin errors++; $display("FAIL lenload_count: sample %0d got %0d expected %0d", i, bus.count, i); end
      end
    end
    bus.cnt_up = 1'b0;
    clk_edge(-1);
    check_queue_empty("lenload");
    do_clear();
  endtask

  task automatic test_reset_mid();
    load_len(1000);
    do_start(1'b0);
    for (int i = 1; i <= 999; i++) begin
      bus.cnt_up = 1'b1;
      clk_edge(i);
    end
    checks++;
    if (bus.count !== 10'd999) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 999", bus.count); end
    #2;
    n_rst = 1'b0;
    #1;
    checks += 4;
    if (bus.count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", bus.count); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    if (bus.held !== 1'b0) begin errors++; $display("FAIL rstmid_held: got %b expected 0", bus.held); end
    if (bus.window_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.window_done); end
    tb_sample = -1;
    @(posedge clk);
    #1;
    bus.cnt_up = 1'b0;
    n_rst = 1'b1;
    clk_edge(-1);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b expected 0", bus.busy); end
    check_queue_empty("rstmid");
  endtask

  task automatic test_default_len();
    load_len(3);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    clk_edge(-1);
    do_start(1'b0);
    for (int i = 1; i <= 1000; i++) begin
      bus.cnt_up = 1'b1;
      if (i == 1000) exp_q.push_back(i);
      clk_edge(i);
      if (i <= 4) begin
        checks++;
        if (bus.count !== CNT_BITS'(i)) begin errors++; $display("FAIL deflen_count: sample %0d got %0d expected %0d", i, bus.count, i); end
      end
    end
    bus.cnt_up = 1'b0;
    clk_edge(-1);
    checks++;
    if (bus.count !== '0) begin errors++; $display("FAIL deflen_wrap: got %0d expected 0", bus.count); end
    check_queue_empty("deflen");
    do_clear();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    tb_sample = -1;
`ifdef SAMPLE_WINDOW_OVR_EN
    exp_ovr_en = 1'b1;
`else
    exp_ovr_en = 1'b0;
`endif
    test_reset();
    test_continuous();
    test_oneshot();
    test_len_zero();
    test_clear_mid();
    test_len_load_in_count();
    test_reset_mid();
    test_default_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
